// File: rtl/kmeans_regfile.sv
// kmeans_regfile
//   Register file between the host register bus and the k-means controller.
//   Holds status, GO, eight centroid registers, the RAM-load address/data
//   pair and the first/last point-address window. Issues a one-cycle go
//   pulse to the controller, serves its zero-latency centroid reads, takes
//   converged-centroid writebacks while busy, streams host point data into
//   the point RAM and raises a level irq when the controller finishes.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   host_addr/wr/rd/wdata      host register access
//   host_rdata, host_rvalid    registered host read data and valid pulse
//   irq                        completion interrupt (level)
//   ctrl_reg_num/reg_write     controller register select and write strobe
//   ctrl_wdata, ctrl_rdata     controller write data, combinational read data
//   ctrl_interrupt             controller completion pulse
//   go                         one-cycle start pulse to the controller
//   first/last_ram_addr        point-address window
//   ram_wr_en/addr/data        point-RAM write port
//
// Register map: 0 status, 1 GO, 2..9 centroids, 10 ram_addr, 11 ram_data,
// 12 first, 13 last; 14-15 read as zero and ignore writes.
// Status bits: [0] busy, [1] done, [2] err_range, [3] err_busy_wr.

module kmeans_regfile #(
   parameter int addrWidth    = 9,
   parameter int dataWidth    = 91,
   parameter int ram_word_len = 50,
   parameter int reg_amount   = 4,
   parameter int centroid_num = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [reg_amount-1:0]   host_addr,
   input  logic                    host_wr,
   input  logic                    host_rd,
   input  logic [dataWidth-1:0]    host_wdata,
   output logic [dataWidth-1:0]    host_rdata,
   output logic                    host_rvalid,
   output logic                    irq,
   input  logic [reg_amount-1:0]   ctrl_reg_num,
   input  logic                    ctrl_reg_write,
   input  logic [dataWidth-1:0]    ctrl_wdata,
   output logic [dataWidth-1:0]    ctrl_rdata,
   input  logic                    ctrl_interrupt,
   output logic                    go,
   output logic [addrWidth-1:0]    first_ram_addr,
   output logic [addrWidth-1:0]    last_ram_addr,
   output logic                    ram_wr_en,
   output logic [addrWidth-1:0]    ram_wr_addr,
   output logic [ram_word_len-1:0] ram_wr_data
);

   localparam int idxWidth = (centroid_num > 1) ? $clog2(centroid_num) : 1;

   localparam logic [reg_amount-1:0] RegStatus    = reg_amount'(0);
   localparam logic [reg_amount-1:0] RegGo        = reg_amount'(1);
   localparam logic [reg_amount-1:0] RegCentFirst = reg_amount'(2);
   localparam logic [reg_amount-1:0] RegCentLast  = reg_amount'(2 + centroid_num - 1);
   localparam logic [reg_amount-1:0] RegRamAddr   = reg_amount'(2 + centroid_num);
   localparam logic [reg_amount-1:0] RegRamData   = reg_amount'(3 + centroid_num);
   localparam logic [reg_amount-1:0] RegFirst     = reg_amount'(4 + centroid_num);
   localparam logic [reg_amount-1:0] RegLast      = reg_amount'(5 + centroid_num);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

   state_t                  state_q;
   logic [dataWidth-1:0]    cent_q [centroid_num];
   logic [addrWidth-1:0]    ramAddr_q;
   logic [ram_word_len-1:0] ramData_q;
   logic [addrWidth-1:0]    firstAddr_q;
   logic [addrWidth-1:0]    lastAddr_q;
   logic                    errRange_q;
   logic                    errBusyWr_q;
   logic                    go_q;
   logic                    irq_q;
   logic [dataWidth-1:0]    hostRdata_q;
   logic                    hostRvalid_q;
   logic                    ramWrEn_q;
   logic [addrWidth-1:0]    ramWrAddr_q;
   logic [ram_word_len-1:0] ramWrData_q;

   logic [dataWidth-1:0]    statusWord;
   logic [dataWidth-1:0]    hostRdata_d;
   logic                    hostWrProtected;

   function automatic logic isCent(input logic [reg_amount-1:0] a);
      return (a >= RegCentFirst) && (a <= RegCentLast);
   endfunction

   function automatic logic [idxWidth-1:0] centIdx(input logic [reg_amount-1:0] a);
      logic [reg_amount-1:0] off;
      off = a - RegCentFirst;
      return off[idxWidth-1:0];
   endfunction

   // Shared read decode for both the host and the controller port; narrow
   // registers zero-extend, GO reads back the live go pulse.
   function automatic logic [dataWidth-1:0] readReg(input logic [reg_amount-1:0] a);
      logic [dataWidth-1:0] v;
      v = '0;
      case (a)
         RegStatus:  v = statusWord;
         RegGo:      v = dataWidth'(go_q);
         RegRamAddr: v = dataWidth'(ramAddr_q);
         RegRamData: v = dataWidth'(ramData_q);
         RegFirst:   v = dataWidth'(firstAddr_q);
         RegLast:    v = dataWidth'(lastAddr_q);
         default:    if (isCent(a)) v = cent_q[centIdx(a)];
      endcase
      return v;
   endfunction

   // Status word is assembled from the FSM state and the sticky error flags.
   always_comb begin
      statusWord = dataWidth'({errBusyWr_q, errRange_q,
                               state_q == StDone, state_q == StBusy});
   end

   // Both read ports see the current (pre-write) register contents.
   always_comb begin
      hostRdata_d = readReg(host_addr);
      ctrl_rdata  = readReg(ctrl_reg_num);
   end

   // Registers that the host may not touch while the controller is running.
   always_comb begin
      hostWrProtected = (host_addr == RegGo) || isCent(host_addr) ||
                        ((host_addr >= RegRamAddr) && (host_addr <= RegLast));
   end

   // Control FSM and register storage. Later assignments in this block take
   // priority: a GO write accepted in DONE overrides the status-read return
   // to IDLE, and a completion interrupt in BUSY wins over a status read.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         for (int i = 0; i < centroid_num; i++) cent_q[i] <= '0;
         ramAddr_q    <= '0;
         ramData_q    <= '0;
         firstAddr_q  <= '0;
         lastAddr_q   <= '0;
         errRange_q   <= 1'b0;
         errBusyWr_q  <= 1'b0;
         go_q         <= 1'b0;
         irq_q        <= 1'b0;
         hostRdata_q  <= '0;
         hostRvalid_q <= 1'b0;
         ramWrEn_q    <= 1'b0;
         ramWrAddr_q  <= '0;
         ramWrData_q  <= '0;
      end else begin
         go_q         <= 1'b0;
         ramWrEn_q    <= 1'b0;
         hostRvalid_q <= host_rd;
         if (host_rd) hostRdata_q <= hostRdata_d;

         if ((state_q == StBusy) && ctrl_reg_write && isCent(ctrl_reg_num))
            cent_q[centIdx(ctrl_reg_num)] <= ctrl_wdata;

         case (state_q)
            StBusy: begin
               if (ctrl_interrupt) begin
                  state_q <= StDone;
                  irq_q   <= 1'b1;
               end
            end
            StDone: begin
               if (host_rd && (host_addr == RegStatus)) begin
                  state_q <= StIdle;
                  irq_q   <= 1'b0;
               end
            end
            default: ;
         endcase

         if (host_wr) begin
            if (host_addr == RegStatus) begin
               if (host_wdata[2]) errRange_q  <= 1'b0;
               if (host_wdata[3]) errBusyWr_q <= 1'b0;
            end else if (state_q == StBusy) begin
               if (hostWrProtected) errBusyWr_q <= 1'b1;
            end else begin
               case (host_addr)
                  RegGo: begin
                     if (host_wdata[0]) begin
                        if (firstAddr_q <= lastAddr_q) begin
                           state_q <= StBusy;
                           go_q    <= 1'b1;
                           irq_q   <= 1'b0;
                        end else begin
                           errRange_q <= 1'b1;
                        end
                     end
                  end
                  RegRamAddr: ramAddr_q <= host_wdata[addrWidth-1:0];
                  RegRamData: begin
                     ramData_q   <= host_wdata[ram_word_len-1:0];
                     ramWrEn_q   <= 1'b1;
                     ramWrAddr_q <= ramAddr_q;
                     ramWrData_q <= host_wdata[ram_word_len-1:0];
                     ramAddr_q   <= ramAddr_q + addrWidth'(1);
                  end
                  RegFirst: firstAddr_q <= host_wdata[addrWidth-1:0];
                  RegLast:  lastAddr_q  <= host_wdata[addrWidth-1:0];
                  default: begin
                     if (isCent(host_addr)) cent_q[centIdx(host_addr)] <= host_wdata;
                  end
               endcase
            end
         end
      end
   end

   assign host_rdata     = hostRdata_q;
   assign host_rvalid    = hostRvalid_q;
   assign irq            = irq_q;
   assign go             = go_q;
   assign first_ram_addr = firstAddr_q;
   assign last_ram_addr  = lastAddr_q;
   assign ram_wr_en      = ramWrEn_q;
   assign ram_wr_addr    = ramWrAddr_q;
   assign ram_wr_data    = ramWrData_q;

endmodule

// File: tb/tb_kmeans_regfile.sv
// tb_kmeans_regfile
//   Directed and randomized bench for kmeans_regfile. A register-map level
//   model (array of register contents plus busy/done/error/irq flags) predicts
//   every output cycle by cycle.

module tb_kmeans_regfile;

   localparam int AW = 9;
   localparam int DW = 91;
   localparam int RW = 50;
   localparam int RA = 4;
   localparam int CN = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [RA-1:0] host_addr;
   logic          host_wr;
   logic          host_rd;
   logic [DW-1:0] host_wdata;
   logic [DW-1:0] host_rdata;
   logic          host_rvalid;
   logic          irq;
   logic [RA-1:0] ctrl_reg_num;
   logic          ctrl_reg_write;
   logic [DW-1:0] ctrl_wdata;
   logic [DW-1:0] ctrl_rdata;
   logic          ctrl_interrupt;
   logic          go;
   logic [AW-1:0] first_ram_addr;
   logic [AW-1:0] last_ram_addr;
   logic          ram_wr_en;
   logic [AW-1:0] ram_wr_addr;
   logic [RW-1:0] ram_wr_data;

   int total = 0;
   int bad   = 0;

   // Model state: plain register contents by map index, plus flags.
   logic [DW-1:0] mem [16];
   bit mBusy, mDone, mErrRange, mErrBusy, mIrq, mGo;

   kmeans_regfile #(
      .addrWidth(AW), .dataWidth(DW), .ram_word_len(RW),
      .reg_amount(RA), .centroid_num(CN)
   ) dut (
      .clk(clk), .rst(rst),
      .host_addr(host_addr), .host_wr(host_wr), .host_rd(host_rd),
      .host_wdata(host_wdata), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
      .irq(irq),
      .ctrl_reg_num(ctrl_reg_num), .ctrl_reg_write(ctrl_reg_write),
      .ctrl_wdata(ctrl_wdata), .ctrl_rdata(ctrl_rdata),
      .ctrl_interrupt(ctrl_interrupt), .go(go),
      .first_ram_addr(first_ram_addr), .last_ram_addr(last_ram_addr),
      .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data)
   );

   always #5 clk = ~clk;

   // Expected read value of a register number in the model.
   function automatic logic [DW-1:0] modelRead(input int a);
      if (a == 0) return DW'({mErrBusy, mErrRange, mDone, mBusy});
      if (a == 1) return DW'(mGo);
      if (a >= 14) return '0;
      return mem[a];
   endfunction

   function automatic logic [DW-1:0] randWide();
      logic [95:0] t;
      t = {$urandom(), $urandom(), $urandom()};
      return t[DW-1:0];
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 16; i++) mem[i] = '0;
      mBusy = 0; mDone = 0; mErrRange = 0; mErrBusy = 0; mIrq = 0; mGo = 0;
   endtask

   // Single comparison point: counts it and reports on mismatch.
   task automatic checkOutput(input string tag, input logic [DW-1:0] obs,
                              input logic [DW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply a synchronous reset and check the quiescent outputs.
   task automatic doReset();
      rst = 1'b1;
      host_wr = 0; host_rd = 0; host_addr = '0; host_wdata = '0;
      ctrl_reg_write = 0; ctrl_reg_num = '0; ctrl_wdata = '0; ctrl_interrupt = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      modelReset();
      checkOutput("rst_go", DW'(go), '0);
      checkOutput("rst_irq", DW'(irq), '0);
      checkOutput("rst_rvalid", DW'(host_rvalid), '0);
      checkOutput("rst_rdata", host_rdata, '0);
      checkOutput("rst_ramwen", DW'(ram_wr_en), '0);
   endtask

   // One clock cycle of stimulus; model predicts, then all outputs checked.
   task automatic applyStimulus(input bit hw, input bit hr, input int a,
                                input logic [DW-1:0] wd, input bit cw, input int cn,
                                input logic [DW-1:0] cd, input bit ci);
      logic [DW-1:0] expRd;
      logic [AW-1:0] expWa;
      logic [RW-1:0] expWd;
      bit expEn, wasBusy, wasDone;
      host_wr = hw; host_rd = hr; host_addr = a[RA-1:0]; host_wdata = wd;
      ctrl_reg_write = cw; ctrl_reg_num = cn[RA-1:0]; ctrl_wdata = cd;
      ctrl_interrupt = ci;
      #1;
      checkOutput("ctrl_rdata", ctrl_rdata, modelRead(cn));
      expRd = modelRead(a);
      wasBusy = mBusy; wasDone = mDone;
      expEn = 0; expWa = '0; expWd = '0; mGo = 0;
      if (wasBusy && cw && cn >= 2 && cn <= 9) mem[cn] = cd;
      if (wasBusy && ci) begin mBusy = 0; mDone = 1; mIrq = 1; end
      if (wasDone && hr && a == 0) begin mDone = 0; mIrq = 0; end
      if (hw) begin
         if (a == 0) begin
            if (wd[2]) mErrRange = 0;
            if (wd[3]) mErrBusy = 0;
         end else if (a >= 14) begin
         end else if (wasBusy) begin
            mErrBusy = 1;
         end else if (a == 1) begin
            if (wd[0]) begin
               if (mem[12] <= mem[13]) begin
                  mBusy = 1; mDone = 0; mIrq = 0; mGo = 1;
               end else mErrRange = 1;
            end
         end else if (a == 11) begin
            expEn = 1;
            expWa = mem[10][AW-1:0];
            expWd = wd[RW-1:0];
            mem[11] = DW'(wd[RW-1:0]);
            mem[10] = (mem[10] + 1) % 512;
         end else if (a == 10 || a == 12 || a == 13) begin
            mem[a] = DW'(wd[AW-1:0]);
         end else begin
            mem[a] = wd;
         end
      end
      @(posedge clk); #1;
      host_wr = 0; host_rd = 0; ctrl_reg_write = 0; ctrl_interrupt = 0;
      checkOutput("go", DW'(go), DW'(mGo));
      checkOutput("irq", DW'(irq), DW'(mIrq));
      checkOutput("rvalid", DW'(host_rvalid), DW'(hr));
      if (hr) checkOutput("rdata", host_rdata, expRd);
      checkOutput("ram_wr_en", DW'(ram_wr_en), DW'(expEn));
      if (expEn) begin
         checkOutput("ram_wr_addr", DW'(ram_wr_addr), DW'(expWa));
         checkOutput("ram_wr_data", DW'(ram_wr_data), DW'(expWd));
      end
      checkOutput("first", DW'(first_ram_addr), DW'(mem[12][AW-1:0]));
      checkOutput("last", DW'(last_ram_addr), DW'(mem[13][AW-1:0]));
   endtask

   task automatic hostWrite(input int a, input logic [DW-1:0] wd);
      applyStimulus(1, 0, a, wd, 0, 0, '0, 0);
   endtask

   task automatic hostRead(input int a);
      applyStimulus(0, 1, a, '0, 0, 0, '0, 0);
   endtask

   task automatic idle();
      applyStimulus(0, 0, 0, '0, 0, 0, '0, 0);
   endtask

   initial begin
      // Reset and read the whole map.
      doReset();
      for (int a = 0; a < 14; a++) begin
         hostRead(a);
         checkOutput("plan_reset_read", host_rdata, '0);
      end

      // Program window and centroids, start the controller.
      hostWrite(12, DW'(5));
      hostWrite(13, DW'(20));
      for (int i = 0; i < 8; i++) hostWrite(2 + i, DW'(8'h11 * (i + 1)));
      hostWrite(1, DW'(1));
      checkOutput("plan_go_pulse", DW'(go), DW'(1));
      applyStimulus(0, 1, 0, '0, 0, 3, '0, 0);
      checkOutput("plan_go_single", DW'(go), '0);
      checkOutput("plan_status_busy", host_rdata, DW'(1));
      ctrl_reg_num = 4'd3; #1;
      checkOutput("plan_ctrl_rdata", ctrl_rdata, DW'(8'h22));

      // Controller writebacks, then completion.
      for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, '0, 1, 2 + i, DW'(8'hA0 + i), 0);
      applyStimulus(0, 0, 0, '0, 0, 0, '0, 1);
      checkOutput("plan_irq_set", DW'(irq), DW'(1));
      for (int i = 0; i < 8; i++) begin
         hostRead(2 + i);
         checkOutput("plan_cent_wb", host_rdata, DW'(8'hA0 + i));
      end
      hostRead(0);
      checkOutput("plan_status_done", host_rdata, DW'(2));
      checkOutput("plan_irq_drop", DW'(irq), '0);
      hostRead(0);
      checkOutput("plan_status_idle", host_rdata, '0);

      // RAM load across the address wrap.
      hostWrite(10, DW'(511));
      hostWrite(11, randWide());
      hostWrite(11, randWide());
      hostWrite(11, randWide());
      hostRead(10);
      checkOutput("plan_ram_addr_wrap", host_rdata, DW'(2));

      // Bad window, then clear the error.
      hostWrite(12, DW'(30));
      hostWrite(13, DW'(10));
      hostWrite(1, DW'(1));
      hostRead(0);
      checkOutput("plan_err_range", host_rdata, DW'(4));
      hostWrite(0, DW'(4));
      hostRead(0);
      checkOutput("plan_err_clear", host_rdata, '0);

      // Protected write while busy, then mid-operation reset.
      hostWrite(12, DW'(5));
      hostWrite(13, DW'(20));
      hostWrite(1, DW'(1));
      hostWrite(2, DW'(8'hFF));
      hostRead(0);
      checkOutput("plan_err_busy", host_rdata, DW'(9));
      hostRead(2);
      checkOutput("plan_cent_kept", host_rdata, DW'(8'hA0));
      doReset();
      idle();
      idle();
      hostRead(0);
      checkOutput("plan_post_rst_status", host_rdata, '0);

      // Randomized traffic against the model.
      doReset();
      for (int n = 0; n < 600; n++) begin
         logic [DW-1:0] wd;
         int a;
         a  = int'($urandom_range(0, 15));
         wd = randWide();
         if (a == 1) wd[0] = ($urandom_range(0, 3) != 0);
         applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, a, wd,
                       $urandom_range(0, 3) == 0, int'($urandom_range(0, 15)),
                       randWide(), $urandom_range(0, 9) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
